// File: rtl/cpu_debug_panel.sv
// Front-panel run/halt/step controller with debounced buttons and register view.
// Optional PC breakpoint enabled by defining DEBUG_PANEL_BREAKPOINT_EN.
module cpu_debug_panel #(
  parameter int NUM_REGS        = 10,
  parameter int DIV_WIDTH       = 24,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SEL_WIDTH       = $clog2(NUM_REGS)
) (
  input  logic                     clock_100mhz,
  input  logic                     reset,
  input  logic [4:0]               speed,
  input  logic                     btn_run,
  input  logic                     btn_step,
  input  logic                     btn_next,
  input  logic                     btn_prev,
  input  logic                     btn_home,
  input  logic [31:0]              pc_in,
  input  logic [NUM_REGS*32-1:0]   regs_in,
`ifdef DEBUG_PANEL_BREAKPOINT_EN
  input  logic [31:0]              breakpoint,
`endif
  output logic                     cpu_enable,
  output logic [1:0]               mode,
  output logic [SEL_WIDTH-1:0]     sel,
  output logic [31:0]              word_out,
  output logic                     halted
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int B_RUN = 0, B_STEP = 1, B_NEXT = 2, B_PREV = 3, B_HOME = 4;

  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } mode_e;

  logic [4:0]            btn_raw;
  logic [4:0]            sync1_q, sync2_q;
  logic [4:0]            level_q, level_d;
  logic [4:0]            edge_q, edge_d;
  logic [4:0][CNT_W-1:0] cnt_q, cnt_d;

  logic [DIV_WIDTH-1:0]  div_q, div_d, mask;
  logic                  tick;
  int unsigned           eff;

  mode_e                 mode_q, mode_d;
  logic                  en_q, en_d;
  logic                  skip_q, skip_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic [31:0]           word_q, word_d;

  assign btn_raw = {btn_home, btn_prev, btn_next, btn_step, btn_run};

  // Counter tracks consecutive synchronised samples that disagree with the accepted level.
  always_comb begin
    level_d = level_q;
    edge_d  = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          level_d[i] = sync2_q[i];
          edge_d[i]  = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    if ({27'd0, speed} >= 32'(DIV_WIDTH)) eff = DIV_WIDTH - 1;
    else                                  eff = {27'd0, speed};
    mask  = {DIV_WIDTH{1'b1}} >> (DIV_WIDTH - 1 - eff);
    tick  = (div_q & mask) == mask;
    div_d = div_q + DIV_WIDTH'(1);
  end

  always_comb begin
    mode_d = mode_q;
    en_d   = 1'b0;
    skip_d = skip_q;
    unique case (mode_q)
      RUN: begin
        if (edge_q[B_RUN]) begin
          mode_d = HALT;
        end else if (tick) begin
`ifdef DEBUG_PANEL_BREAKPOINT_EN
          if (pc_in == breakpoint && !skip_q) mode_d = HALT;
          else                                en_d   = 1'b1;
`else
          en_d = 1'b1;
`endif
        end
      end
      HALT: begin
        if (edge_q[B_RUN]) begin
          mode_d = RUN;
          skip_d = 1'b1;
        end else if (edge_q[B_STEP]) begin
          mode_d = STEP;
          en_d   = 1'b1;
        end
      end
      STEP:    mode_d = HALT;
      default: mode_d = HALT;
    endcase
    if (en_d) skip_d = 1'b0;
  end

  always_comb begin
    sel_d = sel_q;
    if (edge_q[B_HOME]) begin
      sel_d = '0;
    end else if (edge_q[B_NEXT] && !edge_q[B_PREV]) begin
      sel_d = (sel_q == SEL_WIDTH'(NUM_REGS - 1)) ? '0 : sel_q + SEL_WIDTH'(1);
    end else if (edge_q[B_PREV] && !edge_q[B_NEXT]) begin
      sel_d = (sel_q == '0) ? SEL_WIDTH'(NUM_REGS - 1) : sel_q - SEL_WIDTH'(1);
    end
  end

  always_comb begin
    word_d = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (sel_q == SEL_WIDTH'(i)) word_d = regs_in[32*i +: 32];
    end
  end

  always_ff @(posedge clock_100mhz) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      edge_q  <= '0;
      cnt_q   <= '0;
      div_q   <= '0;
      mode_q  <= RUN;
      en_q    <= 1'b0;
      skip_q  <= 1'b1;
      sel_q   <= '0;
      word_q  <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      edge_q  <= edge_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      mode_q  <= mode_d;
      en_q    <= en_d;
      skip_q  <= skip_d;
      sel_q   <= sel_d;
      word_q  <= word_d;
    end
  end

  assign cpu_enable = en_q;
  assign mode       = mode_q;
  assign halted     = (mode_q == HALT);
  assign sel        = sel_q;
  assign word_out   = word_q;

endmodule

// File: tb/tb_cpu_debug_panel.sv
// Self-checking bench for cpu_debug_panel: randomized stimulus against a behavioural model.
module tb_cpu_debug_panel;

  localparam int NR  = 10;
  localparam int DW  = 6;
  localparam int DEB = 4;
  localparam int SW  = $clog2(NR);
  localparam int LAT = 2 + DEB + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [4:0]        speed;
  logic              btn_run, btn_step, btn_next, btn_prev, btn_home;
  logic [31:0]       pc_in, breakpoint;
  logic [NR*32-1:0]  regs_in;
  logic              cpu_enable, halted;
  logic [1:0]        mode;
  logic [SW-1:0]     sel;
  logic [31:0]       word_out;

  int                n_cmp = 0, n_fail = 0;
  int                sel_m;
  logic [31:0]       reg_m [NR];
  int                n_en, n_step, n_en_nostep;

  always #5 clk = ~clk;

  cpu_debug_panel #(
    .NUM_REGS(NR),
    .DIV_WIDTH(DW),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clock_100mhz(clk),
    .reset(reset),
    .speed(speed),
    .btn_run(btn_run),
    .btn_step(btn_step),
    .btn_next(btn_next),
    .btn_prev(btn_prev),
    .btn_home(btn_home),
    .pc_in(pc_in),
    .regs_in(regs_in),
`ifdef DEBUG_PANEL_BREAKPOINT_EN
    .breakpoint(breakpoint),
`endif
    .cpu_enable(cpu_enable),
    .mode(mode),
    .sel(sel),
    .word_out(word_out),
    .halted(halted)
  );

  // Button bit order: 0 run, 1 step, 2 next, 3 prev, 4 home.
  task automatic drive_btns(input logic [4:0] m);
    {btn_home, btn_prev, btn_next, btn_step, btn_run} = m;
  endtask

  task automatic load_regs();
    for (int i = 0; i < NR; i++) begin
      reg_m[i] = $urandom;
      regs_in[32*i +: 32] = reg_m[i];
    end
  endtask

  task automatic press(input logic [4:0] m, input int hold, input int total);
    n_en = 0; n_step = 0; n_en_nostep = 0;
    for (int k = 0; k < total; k++) begin
      @(negedge clk);
      if (k == 0) drive_btns(m);
      if (k == hold) drive_btns(5'b0);
      if (cpu_enable) n_en++;
      if (mode == 2'd2) n_step++;
      if (cpu_enable && mode != 2'd2) n_en_nostep++;
    end
  endtask

  task automatic sel_op(input logic [4:0] m);
    press(m, 6, 16);
    if (m[4])                sel_m = 0;
    else if (m[2] && !m[3])  sel_m = (sel_m + 1) % NR;
    else if (m[3] && !m[2])  sel_m = (sel_m + NR - 1) % NR;
  endtask

  task automatic check_sel(input string name);
    n_cmp++;
    if (sel !== SW'(sel_m)) begin
      n_fail++;
      $display("FAIL %s: sel=%0d expected %0d", name, sel, sel_m);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive_btns(5'b0);
    speed = 5'd3; pc_in = 32'h0; breakpoint = 32'h10;
    load_regs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    sel_m = 0;
    n_cmp++; if (mode !== 2'd1)     begin n_fail++; $display("FAIL reset_mode: %0d expected 1", mode); end
    n_cmp++; if (sel !== '0)        begin n_fail++; $display("FAIL reset_sel: %0d expected 0", sel); end
    n_cmp++; if (word_out !== 32'h0) begin n_fail++; $display("FAIL reset_word: %h expected 0", word_out); end
    n_cmp++; if (cpu_enable !== 1'b0) begin n_fail++; $display("FAIL reset_en: %b expected 0", cpu_enable); end
    n_cmp++; if (halted !== 1'b0)   begin n_fail++; $display("FAIL reset_halted: %b expected 0", halted); end
  endtask

  task automatic test_debounce();
    int base;
    base = sel_m;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 0) btn_next = 1'b1;
      if (k == 3) btn_next = 1'b0;
      n_cmp++;
      if (sel !== SW'(base)) begin
        n_fail++; $display("FAIL glitch k=%0d: sel=%0d expected %0d", k, sel, base);
      end
    end
    for (int k = 0; k < 26; k++) begin
      @(negedge clk);
      if (k == 0)  btn_next = 1'b1;
      if (k == 10) btn_next = 1'b0;
      n_cmp++;
      if (sel !== SW'((k >= LAT) ? base + 1 : base)) begin
        n_fail++; $display("FAIL hold k=%0d: sel=%0d expected %0d", k, sel, (k >= LAT) ? base + 1 : base);
      end
    end
    sel_m = base + 1;
  endtask

  task automatic test_wrap();
    sel_op(5'b10000); check_sel("home");
    sel_op(5'b01000); check_sel("prev_wrap");
    sel_op(5'b00100); check_sel("next_wrap");
    sel_op(5'b00100); check_sel("next_to_1");
    sel_op(5'b10100); check_sel("home_and_next");
    for (int i = 0; i < 4; i++) sel_op(5'b00100);
    check_sel("walk_to_4");
    sel_op(5'b01100); check_sel("next_and_prev");
  endtask

  task automatic test_random_sel();
    logic [4:0] ops [4];
    logic [31:0] nv;
    ops[0] = 5'b00100; ops[1] = 5'b01000; ops[2] = 5'b10000; ops[3] = 5'b01100;
    for (int i = 0; i < 14; i++) begin
      sel_op((i < 12 && $urandom_range(0, 5) == 0) ? ops[2 + $urandom_range(0, 1)] : ops[$urandom_range(0, 1)]);
      check_sel("rand_sel");
      n_cmp++;
      if (word_out !== reg_m[sel_m]) begin
        n_fail++; $display("FAIL rand_word: %h expected %h", word_out, reg_m[sel_m]);
      end
    end
    nv = $urandom;
    @(negedge clk);
    regs_in[32*sel_m +: 32] = nv;
    #1;
    n_cmp++;
    if (word_out !== reg_m[sel_m]) begin
      n_fail++; $display("FAIL live_old: %h expected %h", word_out, reg_m[sel_m]);
    end
    reg_m[sel_m] = nv;
    @(negedge clk);
    n_cmp++;
    if (word_out !== nv) begin
      n_fail++; $display("FAIL live_new: %h expected %h", word_out, nv);
    end
  endtask

  task automatic test_run_rate();
    int speeds [4];
    int per, last, pulses;
    logic prev_en;
    speeds[0] = 3; speeds[1] = $urandom_range(0, DW - 1);
    speeds[2] = 31; speeds[3] = $urandom_range(DW, 30);
    for (int s = 0; s < 4; s++) begin
      per = 1 << (((speeds[s] < DW) ? speeds[s] : DW - 1) + 1);
      @(negedge clk);
      speed = 5'(speeds[s]);
      repeat (140) @(negedge clk);
      last = -1; pulses = 0; prev_en = 1'b0;
      for (int c = 0; c < 4 * per + 2; c++) begin
        @(negedge clk);
        if (cpu_enable) begin
          pulses++;
          n_cmp++;
          if (prev_en) begin
            n_fail++; $display("FAIL rate_width speed=%0d: enable high two cycles", speeds[s]);
          end
          if (last >= 0) begin
            n_cmp++;
            if (c - last != per) begin
              n_fail++; $display("FAIL rate_period speed=%0d: %0d expected %0d", speeds[s], c - last, per);
            end
          end
          last = c;
        end
        prev_en = cpu_enable;
      end
      n_cmp++;
      if (pulses < 4 || pulses > 5) begin
        n_fail++; $display("FAIL rate_count speed=%0d: %0d pulses expected 4..5", speeds[s], pulses);
      end
    end
  endtask

  task automatic test_halt_step();
    speed = 5'd0;
    press(5'b00001, 6, 16);
    n_cmp++; if (mode !== 2'd0) begin n_fail++; $display("FAIL halt_mode: %0d expected 0", mode); end
    n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_ind: %b expected 1", halted); end
    press(5'b00000, 0, 30);
    n_cmp++; if (n_en != 0) begin n_fail++; $display("FAIL halt_quiet: %0d enables expected 0", n_en); end
    for (int i = 0; i < 3; i++) begin
      press(5'b00010, 6, 16);
      n_cmp++; if (n_en != 1)  begin n_fail++; $display("FAIL step_en: %0d expected 1", n_en); end
      n_cmp++; if (n_step != 1) begin n_fail++; $display("FAIL step_mode: %0d cycles expected 1", n_step); end
      n_cmp++; if (n_en_nostep != 0) begin n_fail++; $display("FAIL step_align: %0d expected 0", n_en_nostep); end
      n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("FAIL step_back: halted=%b expected 1", halted); end
    end
    press(5'b00011, 6, 16);
    n_cmp++; if (n_step != 0) begin n_fail++; $display("FAIL run_beats_step: %0d step cycles expected 0", n_step); end
    n_cmp++; if (mode !== 2'd1) begin n_fail++; $display("FAIL run_beats_step_mode: %0d expected 1", mode); end
    n_cmp++; if (n_en == 0) begin n_fail++; $display("FAIL resume_en: %0d expected >0", n_en); end
  endtask

`ifdef DEBUG_PANEL_BREAKPOINT_EN
  task automatic test_breakpoint();
    int waited, got, ens;
    logic [1:0] mode_at;
    speed = 5'd2;
    breakpoint = 32'h10;
    pc_in = 32'h0;
    repeat (20) @(negedge clk);
    pc_in = 32'h10;
    ens = 0; waited = 0;
    while (!halted && waited < 40) begin
      @(negedge clk);
      waited++;
      if (cpu_enable) ens++;
    end
    n_cmp++; if (!halted || waited > 8) begin n_fail++; $display("FAIL bp_halt: halted=%b after %0d expected 1 within 8", halted, waited); end
    n_cmp++; if (ens != 0) begin n_fail++; $display("FAIL bp_no_en: %0d expected 0", ens); end
    got = 0; mode_at = 2'd0;
    for (int k = 0; k < 40 && got == 0; k++) begin
      @(negedge clk);
      if (k == 0) btn_run = 1'b1;
      if (k == 6) btn_run = 1'b0;
      if (cpu_enable) begin
        got = 1; mode_at = mode; pc_in = 32'h14;
      end
    end
    btn_run = 1'b0;
    n_cmp++; if (got != 1 || mode_at !== 2'd1) begin n_fail++; $display("FAIL bp_skip: got=%0d mode=%0d expected 1/1", got, mode_at); end
    ens = 0;
    repeat (24) begin
      @(negedge clk);
      if (cpu_enable) ens++;
    end
    n_cmp++; if (ens != 3 || mode !== 2'd1) begin n_fail++; $display("FAIL bp_run_on: %0d enables mode=%0d expected 3/1", ens, mode); end
    pc_in = 32'h10;
    repeat (12) @(negedge clk);
    n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("FAIL bp_rehit: halted=%b expected 1", halted); end
    press(5'b00001, 6, 3);
    pc_in = 32'h0;
    press(5'b00000, 0, 14);
    n_cmp++; if (mode !== 2'd1) begin n_fail++; $display("FAIL bp_resume: mode=%0d expected 1", mode); end
  endtask
`endif

  task automatic test_reset_mid();
    sel_op(5'b10000);
    for (int i = 0; i < 5; i++) sel_op(5'b00100);
    check_sel("pre_reset_sel5");
    n_cmp++; if (mode !== 2'd1) begin n_fail++; $display("FAIL pre_reset_mode: %0d expected 1", mode); end
    @(negedge clk);
    reset = 1'b0;
    btn_next = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    sel_m = 0;
    n_cmp++; if (mode !== 2'd1)       begin n_fail++; $display("FAIL mid_reset_mode: %0d expected 1", mode); end
    n_cmp++; if (sel !== '0)          begin n_fail++; $display("FAIL mid_reset_sel: %0d expected 0", sel); end
    n_cmp++; if (word_out !== 32'h0)  begin n_fail++; $display("FAIL mid_reset_word: %h expected 0", word_out); end
    n_cmp++; if (cpu_enable !== 1'b0) begin n_fail++; $display("FAIL mid_reset_en: %b expected 0", cpu_enable); end
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      n_cmp++;
      if (sel !== SW'((k >= LAT) ? 1 : 0)) begin
        n_fail++; $display("FAIL held_at_release k=%0d: sel=%0d expected %0d", k, sel, (k >= LAT) ? 1 : 0);
      end
    end
    btn_next = 1'b0;
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_wrap();
    test_random_sel();
    test_run_rate();
    test_halt_step();
`ifdef DEBUG_PANEL_BREAKPOINT_EN
    test_breakpoint();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
